// File: rtl/mem_access_stage_if.sv
// Data-bus request/acknowledge interface between the memory-access stage (master)
// and the data-side devices (slave).
interface mem_access_stage_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage of the MIPS pipeline: runs loads/stores as req/ack bus transactions.
// Optional feature: define MEM_TIMEOUT_EN to abandon a transaction after TIMEOUT unacknowledged cycles.
module mem_access_stage #(
  parameter int TAG_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [3:0]        op_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [4:0]        exc_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              flush,
  output logic              busy,
  mem_access_stage_if.master bus,
  output logic              valid_o,
  output logic [31:0]       rdata_o,
  output logic [4:0]        exc_o,
  output logic [TAG_W-1:0]  tag_o
);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  function automatic logic is_access(input logic [3:0] op);
    return (op >= OP_LW) && (op <= OP_SB);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SW) && (op <= OP_SB);
  endfunction

  function automatic logic [3:0] byte_en(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_SH:   return off[1] ? 4'b1100 : 4'b0011;
      OP_SB:   return 4'b0001 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] w);
    case (op)
      OP_SH:   return {2{w[15:0]}};
      OP_SB:   return {4{w[7:0]}};
      default: return w;
    endcase
  endfunction

  // Little-endian lane select, then sign/zero extension; stores retire with zero data.
  function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> {off, 3'b000});
    h = off[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_LW:   return rd;
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0000, h};
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h000000, b};
      default: return 32'h0;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [1:0]         off_q, off_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               drop_q, drop_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        baddr_q, baddr_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        bwdata_q, bwdata_d;
  logic               valid_q, valid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [4:0]         exc_q, exc_d;
  logic [TAG_W-1:0]   tago_q, tago_d;
  logic               retire;
  logic [31:0]        ret_data;
  logic [4:0]         ret_exc;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    off_d    = off_q;
    tag_d    = tag_q;
    drop_d   = drop_q;
    req_d    = req_q;
    we_d     = we_q;
    baddr_d  = baddr_q;
    be_d     = be_q;
    bwdata_d = bwdata_q;
    valid_d  = 1'b0;
    rdata_d  = rdata_q;
    exc_d    = exc_q;
    tago_d   = tago_q;
    retire   = 1'b0;
    ret_data = 32'h0;
    ret_exc  = 5'd0;
`ifdef MEM_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        // A flush in IDLE discards whatever Execute is presenting this cycle.
        if (valid_i && !flush) begin
          if ((exc_i == 5'd0) && is_access(op_i)) begin
            state_d  = S_WAIT;
            op_d     = op_i;
            off_d    = addr_i[1:0];
            tag_d    = tag_i;
            drop_d   = 1'b0;
            req_d    = 1'b1;
            we_d     = is_store(op_i);
            baddr_d  = {addr_i[31:2], 2'b00};
            be_d     = byte_en(op_i, addr_i[1:0]);
            bwdata_d = store_data(op_i, wdata_i);
`ifdef MEM_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end else begin
            valid_d = 1'b1;
            rdata_d = 32'h0;
            exc_d   = exc_i;
            tago_d  = tag_i;
          end
        end
      end
      S_WAIT: begin
        if (flush) drop_d = 1'b1;
        if (bus.bus_ack) begin
          retire   = 1'b1;
          ret_data = load_ext(op_q, off_q, bus.bus_rdata);
          ret_exc  = 5'd0;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          retire   = 1'b1;
          ret_data = 32'h0;
          ret_exc  = is_store(op_q) ? EXC_ADES : EXC_ADEL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        // The bus cannot abort, so a flushed access still completes but never retires.
        if (retire) begin
          state_d  = S_IDLE;
          req_d    = 1'b0;
          we_d     = 1'b0;
          baddr_d  = 32'h0;
          be_d     = 4'h0;
          bwdata_d = 32'h0;
          valid_d  = !(drop_q || flush);
          rdata_d  = ret_data;
          exc_d    = ret_exc;
          tago_d   = tag_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= 4'h0;
      off_q    <= 2'b00;
      tag_q    <= '0;
      drop_q   <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      baddr_q  <= 32'h0;
      be_q     <= 4'h0;
      bwdata_q <= 32'h0;
      valid_q  <= 1'b0;
      rdata_q  <= 32'h0;
      exc_q    <= 5'd0;
      tago_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      off_q    <= off_d;
      tag_q    <= tag_d;
      drop_q   <= drop_d;
      req_q    <= req_d;
      we_q     <= we_d;
      baddr_q  <= baddr_d;
      be_q     <= be_d;
      bwdata_q <= bwdata_d;
      valid_q  <= valid_d;
      rdata_q  <= rdata_d;
      exc_q    <= exc_d;
      tago_q   <= tago_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign busy          = (state_q == S_WAIT);
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = baddr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = bwdata_q;
  assign valid_o       = valid_q;
  assign rdata_o       = rdata_q;
  assign exc_o         = exc_q;
  assign tag_o         = tago_q;

endmodule
